// File: rtl/mesi_cbus_snoop_resp.sv
// Per-CPU coherence-bus responder: snoops/grants against a local tagless MESI line table.
// Optional snoop hit counter enabled by defining MESI_SNOOP_STATS_EN.
module mesi_cbus_snoop_resp #(
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 4,
  parameter int SNOOP_LAT      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CBUS_CMD_WIDTH-1:0]       cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]           cbus_addr_i,
  output logic                            cbus_ack_o,
  output logic                            wb_req_o,
  output logic [ADDR_WIDTH-1:0]           wb_addr_o,
  input  logic                            wb_ack_i,
  output logic                            cpu_en_wr_o,
  output logic                            cpu_en_rd_o,
  input  logic                            cpu_done_i,
  input  logic                            cpu_excl_i,
  output logic [2*(2**INDEX_WIDTH)-1:0]   line_state_o,
  output logic [15:0]                     snoop_hit_cnt_o,
  output logic [2:0]                      state_dbg_o
);

  localparam int LINES = 2**INDEX_WIDTH;
  localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  localparam logic [1:0] LS_I = 2'd0;
  localparam logic [1:0] LS_S = 2'd1;
  localparam logic [1:0] LS_E = 2'd2;
  localparam logic [1:0] LS_M = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SNOOP, ST_WB, ST_GRANT, ST_ACK, ST_WAIT_NOP
  } state_t;

  state_t                         state, state_nxt;
  logic [CBUS_CMD_WIDTH-1:0]      cmd_q;
  logic [ADDR_WIDTH-1:0]          addr_q;
  logic [CNT_W-1:0]               lat_cnt;
  logic [LINES-1:0][1:0]          line_q;
  logic [INDEX_WIDTH-1:0]         idx;
  logic [1:0]                     cur_line;
  logic                           snoop_resolve;
  logic                           upd_en;
  logic [1:0]                     upd_val;

  assign idx           = addr_q[INDEX_WIDTH-1:0];
  assign cur_line      = line_q[idx];
  assign snoop_resolve = (state == ST_SNOOP) && (lat_cnt == '0);

  // Handshake: a non-NOP cbus command is held by the controller until cbus_ack_o pulses,
  // then must return to NOP before the next command; wb_req_o is held until wb_ack_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cbus_cmd_i != CMD_NOP) begin
          case (cbus_cmd_i)
            CMD_WR_SNOOP, CMD_RD_SNOOP: state_nxt = ST_SNOOP;
            CMD_EN_WR, CMD_EN_RD:       state_nxt = ST_GRANT;
            default:                    state_nxt = ST_ACK;
          endcase
        end
      end
      ST_SNOOP:    if (lat_cnt == '0) state_nxt = (cur_line == LS_M) ? ST_WB : ST_ACK;
      ST_WB:       if (wb_ack_i) state_nxt = ST_ACK;
      ST_GRANT:    if (cpu_done_i) state_nxt = ST_ACK;
      ST_ACK:      state_nxt = ST_WAIT_NOP;
      ST_WAIT_NOP: if (cbus_cmd_i == CMD_NOP) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cbus_ack_o  = (state == ST_ACK);
    wb_req_o    = (state == ST_WB);
    wb_addr_o   = (state == ST_WB) ? addr_q : '0;
    cpu_en_wr_o = (state == ST_IDLE) && (cbus_cmd_i == CMD_EN_WR);
    cpu_en_rd_o = (state == ST_IDLE) && (cbus_cmd_i == CMD_EN_RD);
    state_dbg_o = state;
  end

  // Single-line update for the captured index; at most one fires per command.
  always_comb begin
    upd_en  = 1'b0;
    upd_val = cur_line;
    case (state)
      ST_SNOOP: begin
        if (snoop_resolve && cur_line != LS_M) begin
          if (cmd_q == CMD_WR_SNOOP) begin
            upd_en  = 1'b1;
            upd_val = LS_I;
          end else if (cur_line == LS_E) begin
            upd_en  = 1'b1;
            upd_val = LS_S;
          end
        end
      end
      ST_WB: begin
        if (wb_ack_i) begin
          upd_en  = 1'b1;
          upd_val = (cmd_q == CMD_WR_SNOOP) ? LS_I : LS_S;
        end
      end
      ST_GRANT: begin
        if (cpu_done_i) begin
          upd_en  = 1'b1;
          upd_val = (cmd_q == CMD_EN_WR) ? LS_M : (cpu_excl_i ? LS_E : LS_S);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      lat_cnt <= '0;
      line_q  <= '0;
    end else begin
      if (state == ST_IDLE && cbus_cmd_i != CMD_NOP) begin
        cmd_q   <= cbus_cmd_i;
        addr_q  <= cbus_addr_i;
        lat_cnt <= CNT_W'(SNOOP_LAT - 1);
      end else if (state == ST_SNOOP && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end
      if (upd_en) line_q[idx] <= upd_val;
    end
  end

  assign line_state_o = line_q;

`ifdef MESI_SNOOP_STATS_EN
  logic [15:0] hit_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q <= '0;
    end else if (snoop_resolve && cur_line != LS_I && hit_cnt_q != 16'hFFFF) begin
      hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end

  assign snoop_hit_cnt_o = hit_cnt_q;
`else
  assign snoop_hit_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_mesi_cbus_snoop_resp.sv
// Randomized bench for mesi_cbus_snoop_resp: transaction-level line-table model,
// per-cycle output comparison and a few literal anchors.
module tb_mesi_cbus_snoop_resp;

  localparam int SL = 2;
`ifdef MESI_SNOOP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cbus_cmd_i = '0;
  logic [31:0] cbus_addr_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        cpu_done_i = 1'b0;
  logic        cpu_excl_i = 1'b0;
  logic        cbus_ack_o, wb_req_o, cpu_en_wr_o, cpu_en_rd_o;
  logic [31:0] wb_addr_o;
  logic [31:0] line_state_o;
  logic [15:0] snoop_hit_cnt_o;
  logic [2:0]  state_dbg_o;

  mesi_cbus_snoop_resp #(
    .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .INDEX_WIDTH(4), .SNOOP_LAT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o),
    .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i),
    .cpu_en_wr_o(cpu_en_wr_o), .cpu_en_rd_o(cpu_en_rd_o),
    .cpu_done_i(cpu_done_i), .cpu_excl_i(cpu_excl_i),
    .line_state_o(line_state_o), .snoop_hit_cnt_o(snoop_hit_cnt_o),
    .state_dbg_o(state_dbg_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_count = 0;
  int wb_cycles = 0;
  int last_ack_cyc = 0;
  int issue_cyc = 0;
  bit chk_on = 1'b0;

  // behavioural model: line table in MESI letters, expected outputs for this cycle
  logic [1:0]  m_line [16];
  logic        exp_ack, exp_wb_req, exp_en_wr, exp_en_rd;
  logic [31:0] exp_wb_addr;
  int          exp_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] model_pack();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[2*i +: 2] = m_line[i];
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_on) begin
      check("cbus_ack", {31'b0, cbus_ack_o}, {31'b0, exp_ack});
      check("wb_req", {31'b0, wb_req_o}, {31'b0, exp_wb_req});
      check("wb_addr", wb_addr_o, exp_wb_addr);
      check("cpu_en_wr", {31'b0, cpu_en_wr_o}, {31'b0, exp_en_wr});
      check("cpu_en_rd", {31'b0, cpu_en_rd_o}, {31'b0, exp_en_rd});
      check("line_state", line_state_o, model_pack());
      check("hit_cnt", {16'b0, snoop_hit_cnt_o}, exp_cnt);
    end
    if (cbus_ack_o === 1'b1) begin
      ack_count++;
      last_ack_cyc = cyc;
    end
    if (wb_req_o === 1'b1) wb_cycles++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_ack = 1'b0; exp_wb_req = 1'b0; exp_wb_addr = '0;
    exp_en_wr = 1'b0; exp_en_rd = 1'b0;
  endtask

  task automatic noise();
    wb_ack_i   = 1'($urandom_range(0, 1));
    cpu_done_i = 1'($urandom_range(0, 1));
    cpu_excl_i = 1'($urandom_range(0, 1));
  endtask

  // mode 0: hold cmd/addr, 1: random non-NOP cmd and addr, 2: hold cmd, addr forced to 7
  task automatic drv_mid(input int mode, input logic [2:0] cmd, input logic [31:0] addr);
    case (mode)
      1: begin cbus_cmd_i = 3'($urandom_range(1, 7)); cbus_addr_i = $urandom; end
      2: begin cbus_cmd_i = cmd; cbus_addr_i = 32'd7; end
      default: begin cbus_cmd_i = cmd; cbus_addr_i = addr; end
    endcase
    noise();
  endtask

  task automatic snoop_hit();
    if (STATS && exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] addr, input int wb_lat,
                        input int done_lat, input logic excl, input int hold, input int mode);
    int         idx;
    logic [1:0] cur;
    idx = int'(addr[3:0]);
    cbus_cmd_i = cmd; cbus_addr_i = addr; noise();
    clear_exp();
    exp_en_wr = (cmd == 3'd3);
    exp_en_rd = (cmd == 3'd4);
    issue_cyc = cyc;
    tick();
    exp_en_wr = 1'b0; exp_en_rd = 1'b0;
    if (cmd == 3'd1 || cmd == 3'd2) begin
      for (int i = 0; i < SL; i++) begin drv_mid(mode, cmd, addr); tick(); end
      cur = m_line[idx];
      if (cur != 2'd0) snoop_hit();
      if (cur == 2'd3) begin
        exp_wb_req = 1'b1; exp_wb_addr = addr;
        for (int i = 0; i < wb_lat; i++) begin
          drv_mid(mode, cmd, addr);
          wb_ack_i = (i == wb_lat - 1);
          tick();
        end
        exp_wb_req = 1'b0; exp_wb_addr = '0;
        m_line[idx] = (cmd == 3'd1) ? 2'd0 : 2'd1;
      end else if (cmd == 3'd1) begin
        m_line[idx] = 2'd0;
      end else if (cur == 2'd2) begin
        m_line[idx] = 2'd1;
      end
    end else if (cmd == 3'd3 || cmd == 3'd4) begin
      for (int i = 1; i < done_lat; i++) begin
        drv_mid(mode, cmd, addr); cpu_done_i = 1'b0; tick();
      end
      drv_mid(mode, cmd, addr); cpu_done_i = 1'b1; cpu_excl_i = excl; tick();
      m_line[idx] = (cmd == 3'd3) ? 2'd3 : (excl ? 2'd2 : 2'd1);
    end
    drv_mid(mode, cmd, addr);
    exp_ack = 1'b1;
    tick();
    exp_ack = 1'b0;
    for (int i = 0; i < hold; i++) begin drv_mid(mode, cmd, addr); tick(); end
    cbus_cmd_i = 3'd0; noise();
    tick();
  endtask

  int          a0, w0;
  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 16; i++) m_line[i] = 2'd0;
    clear_exp();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, cbus_ack_o}, 32'd0);
    check("rst_wb_req", {31'b0, wb_req_o}, 32'd0);
    check("rst_wb_addr", wb_addr_o, 32'd0);
    check("rst_lines", line_state_o, 32'd0);
    check("rst_cnt", {16'b0, snoop_hit_cnt_o}, 32'd0);
    rst = 1'b1;
    chk_on = 1'b1;
    tick();

    // EN_RD line 5, exclusive completion two cycles after the grant pulse, held 3 extra cycles
    a0 = ack_count;
    do_cmd(3'd4, 32'd5, 1, 2, 1'b1, 3, 0);
    check("t1_line5_E", {30'b0, line_state_o[11:10]}, 32'd2);
    check("t1_single_ack", ack_count - a0, 32'd1);

    // RD_SNOOP on E line
    do_cmd(3'd2, 32'd5, 1, 1, 1'b0, 0, 0);
    check("t2_latency", last_ack_cyc - issue_cyc, 32'd3);
    check("t2_line5_S", {30'b0, line_state_o[11:10]}, 32'd1);
    check("t2_cnt", {16'b0, snoop_hit_cnt_o}, STATS ? 32'd1 : 32'd0);

    // EN_WR line 3 then WR_SNOOP with write-back accepted after 4 cycles
    do_cmd(3'd3, 32'd3, 1, 1, 1'b0, 0, 0);
    check("t3_line3_M", {30'b0, line_state_o[7:6]}, 32'd3);
    w0 = wb_cycles;
    do_cmd(3'd1, 32'd3, 4, 1, 1'b0, 1, 0);
    check("t3_wb_cycles", wb_cycles - w0, 32'd4);
    check("t3_line3_I", {30'b0, line_state_o[7:6]}, 32'd0);

    // reserved command
    saved = line_state_o;
    do_cmd(3'd6, 32'd5, 1, 1, 1'b0, 0, 0);
    check("t4_latency", last_ack_cyc - issue_cyc, 32'd1);
    check("t4_lines_kept", line_state_o, saved);

    // WR_SNOOP on I line 2 while the bus address moves to 7
    do_cmd(3'd4, 32'd7, 1, 1, 1'b0, 0, 0);
    do_cmd(3'd1, 32'd2, 1, 1, 1'b0, 2, 2);
    check("t5_line7_S", {30'b0, line_state_o[15:14]}, 32'd1);
    check("t5_line2_I", {30'b0, line_state_o[5:4]}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      int gap;
      do_cmd(3'($urandom_range(1, 7)), $urandom & 32'hFFFF_FFF3, $urandom_range(1, 5),
             $urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin cbus_cmd_i = 3'd0; noise(); tick(); end
    end

    // reset while a write-back is pending
    do_cmd(3'd3, 32'd9, 1, 1, 1'b0, 0, 0);
    cbus_cmd_i = 3'd1; cbus_addr_i = 32'd9; wb_ack_i = 1'b0; cpu_done_i = 1'b0;
    clear_exp();
    tick();
    for (int i = 0; i < SL; i++) tick();
    exp_wb_req = 1'b1; exp_wb_addr = 32'd9; snoop_hit();
    tick();
    #2;
    rst = 1'b0;
    cbus_cmd_i = 3'd0;
    clear_exp();
    for (int i = 0; i < 16; i++) m_line[i] = 2'd0;
    exp_cnt = 0;
    #1;
    check("rstmid_wb_req", {31'b0, wb_req_o}, 32'd0);
    check("rstmid_ack", {31'b0, cbus_ack_o}, 32'd0);
    check("rstmid_lines", line_state_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    do_cmd(3'd4, 32'd9, 1, 1, 1'b1, 0, 0);
    check("post_rst_line9_E", {30'b0, line_state_o[19:18]}, 32'd2);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesi_cbus_snoop_resp.md
Name: mesi_cbus_snoop_resp

Overview:
- Per-CPU responder on the coherence bus (cbus); the receiving end of the broadcast controller's command/ack protocol.
- Accepts one cbus command at a time from the broadcast controller and performs the snoop or grant against a local MESI line-state table.
- Performs a write-back handshake when a Modified line is snooped, then returns a single-cycle ack.
- One instance per CPU port (4 in the ISC).

Parameters:
CBUS_CMD_WIDTH, 3, width of cbus command
ADDR_WIDTH, 32, width of snoop address
INDEX_WIDTH, 4, line-state table index bits (2**INDEX_WIDTH lines, index = cbus_addr_i[INDEX_WIDTH-1:0], tagless)
SNOOP_LAT, 2, cycles spent in SNOOP state before the snoop resolves (min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
cbus_cmd_i  in  CBUS_CMD_WIDTH  0 NOP, 1 WR_SNOOP, 2 RD_SNOOP, 3 EN_WR, 4 EN_RD, 5-7 reserved
cbus_addr_i  in  ADDR_WIDTH  address for cbus_cmd_i
cbus_ack_o  out  1  one-cycle command-done pulse
wb_req_o  out  1  write-back request to memory, held until wb_ack_i
wb_addr_o  out  ADDR_WIDTH  write-back address, valid while wb_req_o
wb_ack_i  in  1  write-back accepted
cpu_en_wr_o  out  1  one-cycle pulse: local CPU may perform its write
cpu_en_rd_o  out  1  one-cycle pulse: local CPU may perform its read
cpu_done_i  in  1  local CPU finished the granted access
cpu_excl_i  in  1  with cpu_done_i on a read: no other sharer, so install as E
line_state_o  out  2*(2**INDEX_WIDTH)  packed table, 2 bits/line: 0 I, 1 S, 2 E, 3 M
snoop_hit_cnt_o  out  16  snoop hit counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): FSM IDLE; all lines I; cbus_ack_o, wb_req_o, cpu_en_wr_o, cpu_en_rd_o = 0; wb_addr_o = 0; counter = 0.
- Reset asserted mid-operation aborts everything. The broadcast controller is reset in the same domain.
- States: IDLE, SNOOP, WB, GRANT, ACK, WAIT_NOP.
- IDLE: on cbus_cmd_i != NOP, capture cmd and addr into registers; later cbus_cmd_i/cbus_addr_i changes are ignored until WAIT_NOP exits.
  - WR_SNOOP or RD_SNOOP -> SNOOP, latency counter loaded with SNOOP_LAT-1.
  - EN_WR or EN_RD -> GRANT, with the matching cpu_en_*_o pulsed on the transition cycle.
  - Reserved command -> ACK, no state change.
- SNOOP: counter decrements each cycle. At 0, the line is evaluated:
  - Line M -> WB.
  - Any other state -> apply update, go to ACK.
  - Update rules: WR_SNOOP sets line to I; RD_SNOOP changes E to S; S and I are unchanged.
- WB: wb_req_o=1, wb_addr_o = captured addr, held stable until wb_ack_i.
  - The cycle wb_ack_i=1 is seen: wb_req_o drops next cycle, line set to I (WR_SNOOP) or S (RD_SNOOP), -> ACK.
  - wb_ack_i outside WB is ignored.
- GRANT: wait for cpu_done_i; no timeout.
  - EN_WR sets line to M.
  - EN_RD sets line to E if cpu_excl_i=1, else S.
  - Then -> ACK.
  - cpu_done_i in any other state is ignored.
- ACK: cbus_ack_o=1 for exactly one cycle, -> WAIT_NOP.
- WAIT_NOP: stay until cbus_cmd_i==NOP, then -> IDLE. A command still asserted after ack must never be re-acked.
- A new command can be accepted the cycle after the NOP is seen.
- Minimum command-to-ack latency:
  - reserved: 1 cycle
  - snoop, non-M line: SNOOP_LAT+1 cycles
  - snoop, M line: SNOOP_LAT+2+wb latency
- line_state_o is the registered table; an update is visible the cycle after the transition.
- Only one line is modified per command.

Optional Feature:
- Macro MESI_SNOOP_STATS_EN.
- Defined: snoop_hit_cnt_o increments by 1 on each snoop that finds its line not I at SNOOP resolution. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: no counter logic; snoop_hit_cnt_o tied to 0.

Test Plan:
- Reset, then cmd=EN_RD addr=5, hold until ack; cpu_done_i=1, cpu_excl_i=1 two cycles after cpu_en_rd_o -> line 5 = E; single ack; cmd held 3 more cycles -> no second ack.
- Line 5 E, RD_SNOOP addr=5, SNOOP_LAT=2 -> ack 3 cycles after accept; line 5 = S; no wb_req_o; counter = 1 with macro.
- EN_WR addr=3 completes (line 3 = M); WR_SNOOP addr=3; wb_ack_i delayed 4 cycles -> wb_req_o high 4 cycles with wb_addr_o=3, stable; then line 3 = I and ack follows.
- cmd=6 (reserved) -> ack next cycle; line_state_o unchanged; snoop counter unchanged.
- WR_SNOOP on I line with cbus_addr_i changed to 7 mid-SNOOP -> captured line updated only; line 7 untouched.
- rst=0 asserted while wb_req_o=1 -> wb_req_o and cbus_ack_o low immediately; all lines I; FSM accepts a new command after rst=1.
